// File: rtl/heartbeat_health_monitor.sv
// Heartbeat health monitor: classifies beat intervals as good/late/timeout and
// walks an INIT/OK/WARN/FAULT health state with confirm/recover hysteresis.
module heartbeat_health_monitor #(
  parameter int unsigned WARN_CYCLES    = 37500000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int          CNT_W          = 26,
  parameter int unsigned CONFIRM_N      = 3,
  parameter int unsigned RECOVER_N      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hb_in,
  output logic       ok_on,
  output logic       warn_blink_en,
  output logic       fault_blink_en,
  output logic [1:0] state_code,
  output logic [7:0] fault_count
);

  localparam int unsigned HYST_MAX = (CONFIRM_N > RECOVER_N) ? CONFIRM_N : RECOVER_N;
  localparam int          HYST_W   = $clog2(HYST_MAX + 1);

  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_OK    = 2'b01;
  localparam logic [1:0] S_WARN  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam logic [CNT_W-1:0]  WARN_LIM  = CNT_W'(WARN_CYCLES);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HYST_W-1:0] CONFIRM_V = HYST_W'(CONFIRM_N);
  localparam logic [HYST_W-1:0] RECOVER_V = HYST_W'(RECOVER_N);

  logic              r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0]  r_ivl;
  logic [1:0]        r_state;
  logic [HYST_W-1:0] r_badCnt, r_goodCnt;
  logic              r_okOn, r_warnEn, r_faultEn;
  logic [7:0]        r_faultCnt;

  logic              w_beat, w_isGood, w_isLate, w_timeout;
  logic [1:0]        w_stateNxt;
  logic [HYST_W-1:0] w_badNxt, w_goodNxt, w_badInc, w_goodInc;

  // hb_in is asynchronous: two flops to resolve metastability, a third for the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= hb_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_beat    = r_sync2 & ~r_sync3;
  assign w_isGood  = w_beat & (r_ivl <= WARN_LIM);
  assign w_isLate  = w_beat & (r_ivl > WARN_LIM);
  assign w_timeout = ~w_beat & (r_ivl == TMO_LAST);
  assign w_badInc  = r_badCnt + HYST_W'(1);
  assign w_goodInc = r_goodCnt + HYST_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_ivl <= '0;
    else if (w_beat || w_timeout) r_ivl <= '0;
    else                          r_ivl <= r_ivl + CNT_W'(1);
  end

  always_comb begin
    w_stateNxt = r_state;
    w_badNxt   = r_badCnt;
    w_goodNxt  = r_goodCnt;
    case (r_state)
      S_INIT: begin
        if (w_isGood)       w_stateNxt = S_OK;
        else if (w_isLate)  w_stateNxt = S_WARN;
        else if (w_timeout) w_stateNxt = S_FAULT;
      end
      S_OK: begin
        if (w_timeout) w_stateNxt = S_FAULT;
        else if (w_isLate) begin
          if (w_badInc == CONFIRM_V) w_stateNxt = S_WARN;
          else                       w_badNxt   = w_badInc;
        end else if (w_isGood) w_badNxt = '0;
      end
      S_WARN: begin
        if (w_timeout) w_stateNxt = S_FAULT;
        else if (w_isGood) begin
          if (w_goodInc == RECOVER_V) w_stateNxt = S_OK;
          else                        w_goodNxt  = w_goodInc;
        end else if (w_isLate) w_goodNxt = '0;
      end
      default: begin
        // FAULT only ever recovers one level, to WARN
        if (w_isGood) begin
          if (w_goodInc == RECOVER_V) w_stateNxt = S_WARN;
          else                        w_goodNxt  = w_goodInc;
        end else if (w_isLate || w_timeout) w_goodNxt = '0;
      end
    endcase
    if (w_stateNxt != r_state) begin
      w_badNxt  = '0;
      w_goodNxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_badCnt  <= '0;
      r_goodCnt <= '0;
    end else begin
      r_state   <= w_stateNxt;
      r_badCnt  <= w_badNxt;
      r_goodCnt <= w_goodNxt;
    end
  end

  // Outputs decode the next state so they switch on the same edge as r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_okOn     <= 1'b0;
      r_warnEn   <= 1'b0;
      r_faultEn  <= 1'b0;
      r_faultCnt <= 8'd0;
    end else begin
      r_okOn    <= (w_stateNxt == S_OK);
      r_warnEn  <= (w_stateNxt == S_WARN);
      r_faultEn <= (w_stateNxt == S_FAULT);
      if ((w_stateNxt == S_FAULT) && (r_state != S_FAULT) && (r_faultCnt != 8'hFF))
        r_faultCnt <= r_faultCnt + 8'd1;
    end
  end

  assign ok_on          = r_okOn;
  assign warn_blink_en  = r_warnEn;
  assign fault_blink_en = r_faultEn;
  assign state_code     = r_state;
  assign fault_count    = r_faultCnt;

endmodule

// File: tb/tb_heartbeat_health_monitor.sv
// Bench for heartbeat_health_monitor: directed vector table, reset and
// saturation sequences, and random beats checked every cycle against a model.
module tb_heartbeat_health_monitor;

  localparam int WARN    = 60;
  localparam int TMO     = 100;
  localparam int CONFIRM = 3;
  localparam int RECOVER = 4;

  localparam int H_INIT  = 0;
  localparam int H_OK    = 1;
  localparam int H_WARN  = 2;
  localparam int H_FAULT = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       hb_in = 1'b0;
  logic       ok_on, warn_blink_en, fault_blink_en;
  logic [1:0] state_code;
  logic [7:0] fault_count;

  heartbeat_health_monitor #(
    .WARN_CYCLES(WARN), .TIMEOUT_CYCLES(TMO), .CNT_W(8),
    .CONFIRM_N(CONFIRM), .RECOVER_N(RECOVER)
  ) dut (
    .clk(clk), .rst(rst), .hb_in(hb_in),
    .ok_on(ok_on), .warn_blink_en(warn_blink_en), .fault_blink_en(fault_blink_en),
    .state_code(state_code), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       health;
    int       lateRun;
    int       goodRun;
    int       sinceEvent;
    int       faults;
    bit [2:0] hbSeen;
  } model_t;

  typedef struct {
    int ivl;
    int silence;
    int expHealth;
    int expFaults;
  } vec_t;

  model_t mdl;
  vec_t   vecs[$];
  int     compared   = 0;
  int     mismatched = 0;
  bit     checkEn    = 0;

  function automatic model_t resetModel();
    model_t m;
    m.health = H_INIT; m.lateRun = 0; m.goodRun = 0;
    m.sinceEvent = 0; m.faults = 0; m.hbSeen = 3'b000;
    return m;
  endfunction

  // hbSeen[0] is the newest sample; a beat is a rise seen two samples back
  function automatic model_t stepModel(model_t m, logic hb);
    model_t n = m;
    bit beat, good, late, tmo;
    beat = m.hbSeen[1] && !m.hbSeen[2];
    good = beat && (m.sinceEvent <= WARN);
    late = beat && !good;
    tmo  = !beat && (m.sinceEvent == TMO - 1);
    n.sinceEvent = (beat || tmo) ? 0 : m.sinceEvent + 1;
    n.hbSeen = {m.hbSeen[1:0], hb};
    case (m.health)
      H_INIT: if (good) n.health = H_OK; else if (late) n.health = H_WARN; else if (tmo) n.health = H_FAULT;
      H_OK: begin
        if (tmo) n.health = H_FAULT;
        else if (late) begin n.lateRun++; if (n.lateRun >= CONFIRM) n.health = H_WARN; end
        else if (good) n.lateRun = 0;
      end
      H_WARN: begin
        if (tmo) n.health = H_FAULT;
        else if (good) begin n.goodRun++; if (n.goodRun >= RECOVER) n.health = H_OK; end
        else if (late) n.goodRun = 0;
      end
      default: begin
        if (good) begin n.goodRun++; if (n.goodRun >= RECOVER) n.health = H_WARN; end
        else if (late || tmo) n.goodRun = 0;
      end
    endcase
    if (n.health != m.health) begin
      n.lateRun = 0;
      n.goodRun = 0;
      if (n.health == H_FAULT && n.faults < 255) n.faults++;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= resetModel();
    else     mdl <= stepModel(mdl, hb_in);
  end

  function automatic logic [12:0] expectVec(int health, int faults);
    logic [1:0] code = health[1:0];
    logic [7:0] cnt  = faults[7:0];
    return {(health == H_OK), (health == H_WARN), (health == H_FAULT), code, cnt};
  endfunction

  task automatic checkOutput(string name, logic [12:0] expected);
    logic [12:0] actual = {ok_on, warn_blink_en, fault_blink_en, state_code, fault_count};
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got ok/warn/fault/code/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               name, $time, actual[12], actual[11], actual[10], actual[9:8], actual[7:0],
               expected[12], expected[11], expected[10], expected[9:8], expected[7:0]);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput("cycle", expectVec(mdl.health, mdl.faults));
  end

  // Raise hb_in so the resulting beat is classified against interval 'ivl'
  task automatic applyStimulus(int ivl);
    int budget = 0;
    while (mdl.sinceEvent != ivl - 2 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 300) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL beatWait: interval %0d never reached within %0d cycles", ivl, budget);
    end
    hb_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hb_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic addVec(int ivl, int silence, int health, int faults);
    vec_t v;
    v.ivl = ivl; v.silence = silence; v.expHealth = health; v.expFaults = faults;
    vecs.push_back(v);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addVec(40, 0, H_OK, 0);   addVec(40, 0, H_OK, 0);   addVec(80, 0, H_OK, 0);
    addVec(80, 0, H_OK, 0);   addVec(40, 0, H_OK, 0);   addVec(80, 0, H_OK, 0);
    addVec(80, 0, H_OK, 0);   addVec(80, 0, H_WARN, 0); addVec(60, 0, H_WARN, 0);
    addVec(61, 0, H_WARN, 0); addVec(60, 0, H_WARN, 0); addVec(40, 0, H_WARN, 0);
    addVec(40, 0, H_WARN, 0); addVec(40, 0, H_OK, 0);   addVec(61, 0, H_OK, 0);
    addVec(99, 0, H_OK, 0);   addVec(99, 0, H_WARN, 0);
    for (int i = 0; i < 3; i++) addVec(40, 0, H_WARN, 0);
    addVec(40, 0, H_OK, 0);
    addVec(0, 100, H_FAULT, 1);
    addVec(0, 250, H_FAULT, 1);
    for (int i = 0; i < 3; i++) addVec(40, 0, H_FAULT, 1);
    addVec(80, 0, H_FAULT, 1);
    for (int i = 0; i < 3; i++) addVec(40, 0, H_FAULT, 1);
    addVec(40, 0, H_WARN, 1);
    for (int i = 0; i < 3; i++) addVec(40, 0, H_WARN, 1);
    for (int i = 0; i < 4; i++) addVec(40, 0, H_OK, 1);

    repeat (3) @(negedge clk);
    checkOutput("resetState", 13'd0);
    rst = 1'b0;
    checkEn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].silence > 0) repeat (vecs[i].silence) @(negedge clk);
      else applyStimulus(vecs[i].ivl);
      checkOutput($sformatf("vec%0d", i), expectVec(vecs[i].expHealth, vecs[i].expFaults));
    end

    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstHold1", 13'd0);
    @(negedge clk);
    checkOutput("rstHold2", 13'd0);
    rst = 1'b0;
    applyStimulus(30);
    checkOutput("postResetBeat", expectVec(H_OK, 0));

    $display("[TB] random beat phase");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(9, 0) < 2) repeat ($urandom_range(250, 1)) @(negedge clk);
      else applyStimulus($urandom_range(99, 4));
    end

    $display("[TB] fault counter saturation phase");
    for (int k = 0; k < 300; k++) begin
      repeat (4) applyStimulus(10);
      repeat (101) @(negedge clk);
    end
    checkOutput("faultSaturate", expectVec(H_FAULT, 255));

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
